// File: rtl/radar_sweep_scheduler.sv
// radar_sweep_scheduler: steps a servo across NUM_SLOTS positions and takes one HC-SR04
// range sample per slot. Optional macro RADAR_AVG_EN: two shots per slot, published as their mean.
`timescale 1ns/1ps
module radar_sweep_scheduler #(
  parameter int NUM_SLOTS        = 7,
  parameter int SLOT_W           = 3,
  parameter int SETTLE_CYC       = 270000,
  parameter int TRIG_CYC         = 270,
  parameter int ECHO_TIMEOUT_CYC = 200000,
  parameter int PERIOD_CYC       = 1620000,
  parameter int CNT_W            = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [SLOT_W-1:0] slot,
  output logic              dir,
  output logic              busy,
  output logic              sample_valid,
  output logic [SLOT_W-1:0] sample_slot,
  output logic [CNT_W-1:0]  sample_count,
  output logic              sample_timeout
);

  localparam int TMAX0 = (SETTLE_CYC > TRIG_CYC) ? SETTLE_CYC : TRIG_CYC;
  localparam int TMAX  = (TMAX0 > ECHO_TIMEOUT_CYC) ? TMAX0 : ECHO_TIMEOUT_CYC;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int PW    = $clog2(PERIOD_CYC + 1);

  localparam logic [TW-1:0]     SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]     TRIG_LAST   = TW'(TRIG_CYC - 1);
  localparam logic [TW-1:0]     WAIT_LAST   = TW'(ECHO_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_CNT      = CNT_W'(ECHO_TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  MEAS_LAST   = CNT_W'(ECHO_TIMEOUT_CYC - 1);
  localparam logic [PW-1:0]     PER_MAX     = PW'(PERIOD_CYC);
  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(NUM_SLOTS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_TRIG   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_MEAS   = 3'd4;
  localparam logic [2:0] S_ADV    = 3'd5;

  logic [2:0]       state;
  logic [TW-1:0]    tmr;
  logic [PW-1:0]    per_cnt;
  logic             fired;
  logic [CNT_W-1:0] ecnt;
  logic [2:0]       esync;
  logic             es, rise;
  logic             settle_done, per_ok, go_trig;
  logic             meas_done, meas_to;
  logic [CNT_W-1:0] meas_cnt;
  logic             pub, rearm, pub_to;
  logic [CNT_W-1:0] pub_cnt;

  // [1:0] is the synchronizer, [2] the previous synced value for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) esync <= '0;
    else     esync <= {esync[1:0], echo};

  assign es   = esync[1];
  assign rise = esync[1] & ~esync[2];

  assign trig        = (state == S_TRIG);
  assign busy        = (state != S_IDLE);
  assign settle_done = (tmr >= SETTLE_LAST);
  assign per_ok      = !fired || (per_cnt >= PER_MAX);
  assign go_trig     = (state == S_SETTLE) && settle_done && per_ok;

  // Loads 1 on the trig-rise edge so the next rise lands exactly PERIOD_CYC later.
  always_ff @(posedge clk or posedge rst)
    if (rst)                    per_cnt <= '0;
    else if (go_trig)           per_cnt <= PW'(1);
    else if (per_cnt < PER_MAX) per_cnt <= per_cnt + 1'b1;

  always_comb begin
    meas_done = 1'b0;
    meas_to   = 1'b0;
    meas_cnt  = ecnt;
    case (state)
      S_WAIT: if (!rise && tmr == WAIT_LAST) begin
        meas_done = 1'b1;
        meas_to   = 1'b1;
        meas_cnt  = TO_CNT;
      end
      S_MEAS: if (!es) begin
        meas_done = 1'b1;
      end else if (ecnt >= MEAS_LAST) begin
        meas_done = 1'b1;
        meas_to   = 1'b1;
        meas_cnt  = TO_CNT;
      end
      default: ;
    endcase
  end

`ifdef RADAR_AVG_EN
  logic             shot, to0;
  logic [CNT_W-1:0] c0;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum     = {1'b0, c0} + {1'b0, meas_cnt};
    pub     = meas_done && shot;
    rearm   = meas_done && !shot;
    pub_to  = to0 | meas_to;
    pub_cnt = pub_to ? TO_CNT : CNT_W'(sum >> 1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shot <= 1'b0;
      to0  <= 1'b0;
      c0   <= '0;
    end else if (meas_done) begin
      shot <= !shot;
      to0  <= meas_to;
      c0   <= meas_cnt;
    end
`else
  assign pub     = meas_done;
  assign rearm   = 1'b0;
  assign pub_to  = meas_to;
  assign pub_cnt = meas_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tmr            <= '0;
      fired          <= 1'b0;
      ecnt           <= '0;
      slot           <= '0;
      dir            <= 1'b0;
      sample_valid   <= 1'b0;
      sample_slot    <= '0;
      sample_count   <= '0;
      sample_timeout <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (pub) begin
        sample_valid   <= 1'b1;
        sample_slot    <= slot;
        sample_count   <= pub_cnt;
        sample_timeout <= pub_to;
      end
      case (state)
        S_IDLE: if (enable) begin
          state <= S_SETTLE;
          tmr   <= '0;
        end
        S_SETTLE: if (go_trig) begin
          state <= S_TRIG;
          tmr   <= '0;
          fired <= 1'b1;
        end else if (!settle_done) begin
          tmr <= tmr + 1'b1;
        end
        S_TRIG: if (tmr == TRIG_LAST) begin
          state <= S_WAIT;
          tmr   <= '0;
        end else begin
          tmr <= tmr + 1'b1;
        end
        // The rise cycle itself is the first echo-high clock, hence the load of 1.
        S_WAIT: if (rise) begin
          state <= S_MEAS;
          ecnt  <= CNT_W'(1);
        end else if (meas_done) begin
          state <= rearm ? S_SETTLE : S_ADV;
          tmr   <= SETTLE_LAST;
        end else begin
          tmr <= tmr + 1'b1;
        end
        S_MEAS: if (meas_done) begin
          state <= rearm ? S_SETTLE : S_ADV;
          tmr   <= SETTLE_LAST;
        end else begin
          ecnt <= ecnt + 1'b1;
        end
        S_ADV: begin
          if (!dir) begin
            if (slot == SLOT_LAST) begin
              dir  <= 1'b1;
              slot <= slot - 1'b1;
            end else begin
              slot <= slot + 1'b1;
            end
          end else begin
            if (slot == '0) begin
              dir  <= 1'b0;
              slot <= slot + 1'b1;
            end else begin
              slot <= slot - 1'b1;
            end
          end
          state <= enable ? S_SETTLE : S_IDLE;
          tmr   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radar_sweep_scheduler.sv
// Bench for radar_sweep_scheduler: a per-shot timeline computed arithmetically up front,
// compared against the DUT every cycle, plus literal pins and an async-reset check.
`timescale 1ns/1ps
module tb_radar_sweep_scheduler;
  localparam int NS = 4, SW = 3, SET = 10, TRG = 5, TO = 50, PER = 100, CW = 18;
  localparam int MAXC  = 3000;
  localparam int NSHOT = 18;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, echo = 1'b0;
  logic trig, dir, busy, sample_valid, sample_timeout;
  logic [SW-1:0] slot, sample_slot;
  logic [CW-1:0] sample_count;

  radar_sweep_scheduler #(
    .NUM_SLOTS(NS), .SLOT_W(SW), .SETTLE_CYC(SET), .TRIG_CYC(TRG),
    .ECHO_TIMEOUT_CYC(TO), .PERIOD_CYC(PER), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig), .slot(slot),
    .dir(dir), .busy(busy), .sample_valid(sample_valid), .sample_slot(sample_slot),
    .sample_count(sample_count), .sample_timeout(sample_timeout)
  );

  always #5 clk = ~clk;

  // expected per-cycle timeline; cycle 0 is the first clock after reset release
  bit eraw [MAXC];
  bit en_a [MAXC];
  bit x_trig [MAXC], x_busy [MAXC], x_valid [MAXC], x_dir [MAXC], x_to [MAXC];
  int x_slot [MAXC], x_sslot [MAXC], x_cnt [MAXC];
  int v_q[$], rise_q[$];
  int last_v;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit es_at(input int t);
    return (t >= 2) ? eraw[t-2] : 1'b0;
  endfunction

  // ping-pong position of the k-th sample, and dir held while that sample is taken
  function automatic int slot_of(input int k);
    int p;
    p = k % (2 * (NS - 1));
    return (p < NS) ? p : 2 * (NS - 1) - p;
  endfunction

  function automatic int dir_of(input int k);
    return (k > 0 && ((k - 1) % (2 * (NS - 1))) >= NS - 1) ? 1 : 0;
  endfunction

  task automatic build_model();
    int s, prev;
    bit first;
    for (int t = 0; t < MAXC; t++) begin
      eraw[t] = 0; en_a[t] = 1; x_trig[t] = 0; x_busy[t] = 0; x_valid[t] = 0;
      x_dir[t] = 0; x_to[t] = 0; x_slot[t] = 0; x_sslot[t] = 0; x_cnt[t] = 0;
    end
    s = 1; prev = 0; first = 1;
    for (int i = 0; i < NSHOT; i++) begin
      int d, h, pre, drop, rise, w, r, n, v, cnt, tmo, e;
      pre = 0; drop = -1; d = 0; h = 0;
      case (i)
        0: begin d = 3; h = 20; end
        1: begin d = 0; h = 0; end
        2: begin d = 3; h = 80; end
        8: begin pre = 4; d = 10; h = 7; end
        9: begin d = 5; h = 20; drop = 3; end
        default:
          if (i < 8) begin d = $urandom_range(40); h = $urandom_range(45, 1); end
          else       begin d = $urandom_range(55); h = $urandom_range(40); end
      endcase
      rise = first ? s + SET : ((s + SET > prev + PER) ? s + SET : prev + PER);
      first = 0; prev = rise; rise_q.push_back(rise);
      for (int k = 0; k < TRG; k++) x_trig[rise+k] = 1;
      w = rise + TRG;
      if (pre > 0) for (int t = rise; t < w + pre; t++) eraw[t] = 1;
      for (int t = w + d; t < w + d + h; t++) eraw[t] = 1;
      r = -1;
      for (int t = w; t < w + TO; t++) if (r < 0 && es_at(t) && !es_at(t-1)) r = t;
      if (r < 0) begin
        v = w + TO; cnt = TO; tmo = 1;
      end else begin
        n = 0;
        while (n < TO && es_at(r + n)) n++;
        if (n >= TO) begin v = r + TO; cnt = TO; tmo = 1; end
        else         begin v = r + n + 1; cnt = n; tmo = 0; end
      end
      e = v;
      if (drop >= 0) begin
        e = v + 100;
        for (int t = r + drop; t < e; t++) en_a[t] = 0;
      end
      for (int t = s; t <= v; t++) begin
        x_busy[t] = 1; x_slot[t] = slot_of(i); x_dir[t] = bit'(dir_of(i));
      end
      for (int t = v + 1; t < MAXC; t++) begin
        x_slot[t] = slot_of(i + 1); x_dir[t] = bit'(dir_of(i + 1));
      end
      x_valid[v] = 1;
      for (int t = v; t < MAXC; t++) begin
        x_sslot[t] = slot_of(i); x_cnt[t] = cnt; x_to[t] = bit'(tmo);
      end
      v_q.push_back(v);
      s = en_a[v] ? v + 1 : e + 1;
      last_v = v;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_slot[$], s_cnt[$], s_to[$], rise_obs[$], lens[$];
    int exp_seq[8];
    int hi, c_rise;
    bit trig_d, found;
    exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
    build_model();
    // hand-derived anchors for the model's first shots
    chk("model_v0", v_q[0], 42);
    chk("model_cnt0", x_cnt[v_q[0]], 20);
    chk("model_v1", v_q[1], 166);
    chk("model_rise2", rise_q[2], 211);

    rst = 1; enable = 0; echo = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_trig", trig, 0);   chk("rst_busy", busy, 0);
    chk("rst_slot", slot, 0);   chk("rst_dir", dir, 0);
    chk("rst_valid", sample_valid, 0); chk("rst_sslot", sample_slot, 0);
    chk("rst_count", sample_count, 0); chk("rst_timeout", sample_timeout, 0);

    @(posedge clk); #1; rst = 0;
    trig_d = 0; hi = 0;
    for (int c = 0; c <= last_v; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      enable = en_a[c]; echo = eraw[c];
      @(negedge clk);
      chk($sformatf("trig@%0d", c), trig, x_trig[c]);
      chk($sformatf("busy@%0d", c), busy, x_busy[c]);
      chk($sformatf("slot@%0d", c), slot, x_slot[c]);
      chk($sformatf("dir@%0d", c), dir, x_dir[c]);
      chk($sformatf("valid@%0d", c), sample_valid, x_valid[c]);
      chk($sformatf("sslot@%0d", c), sample_slot, x_sslot[c]);
      chk($sformatf("count@%0d", c), sample_count, x_cnt[c]);
      chk($sformatf("timeout@%0d", c), sample_timeout, x_to[c]);
      if (trig && !trig_d) rise_obs.push_back(c);
      if (trig) hi++;
      if (!trig && trig_d) begin lens.push_back(hi); hi = 0; end
      if (sample_valid) begin
        s_slot.push_back(int'(sample_slot));
        s_cnt.push_back(int'(sample_count));
        s_to.push_back(int'(sample_timeout));
      end
      trig_d = trig;
    end

    chk("n_samples", s_slot.size(), NSHOT);
    for (int i = 0; i < 8; i++) chk($sformatf("slot_seq[%0d]", i), s_slot[i], exp_seq[i]);
    chk("s0_count", s_cnt[0], 20);  chk("s0_timeout", s_to[0], 0);
    chk("s1_count", s_cnt[1], 50);  chk("s1_timeout", s_to[1], 1);
    chk("s2_count", s_cnt[2], 50);  chk("s2_timeout", s_to[2], 1);
    chk("trig_len0", lens[0], 5);
    for (int i = 1; i < rise_obs.size(); i++)
      chk($sformatf("period_gap_ok[%0d]", i), (rise_obs[i] - rise_obs[i-1]) >= PER, 1);

    // run to the next trigger, then assert reset in the middle of the pulse
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(posedge clk); #1; enable = 1; echo = 0;
      if (trig) found = 1;
    end
    chk("trig_before_reset", found, 1);
    #2; rst = 1; #1;
    chk("mid_rst_trig", trig, 0);   chk("mid_rst_busy", busy, 0);
    chk("mid_rst_slot", slot, 0);   chk("mid_rst_dir", dir, 0);
    chk("mid_rst_valid", sample_valid, 0); chk("mid_rst_sslot", sample_slot, 0);
    chk("mid_rst_count", sample_count, 0); chk("mid_rst_timeout", sample_timeout, 0);

    // first trigger after reset must not be held off by the earlier pulse
    @(posedge clk); #1; rst = 0; enable = 1;
    found = 0; c_rise = -1;
    for (int c = 0; c < 200 && !found; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (trig) begin found = 1; c_rise = c; end
    end
    chk("first_trig_after_reset", c_rise, SET + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
